// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity modes
// and the three-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flags a dropped write on overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_overrun;
    logic             w_rd;
    logic             w_wr;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd      = i_rd_en & ~o_empty;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_wr      = i_wr_en & (~o_full | w_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_overrun = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_overrun <= i_wr_en & o_full & ~w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit majority vote, frame FSM with
// break handling, and a receive FIFO toward the consumer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_H_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_H    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_H_P1 = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    C_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    C_STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_e            r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync_d;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_push;

    logic                 w_fall;
    logic                 w_timed;
    logic                 w_wrap;
    logic                 w_at_h1;
    logic                 w_vote;
    logic                 w_par_exp;
    logic                 w_ferr_next;
    logic                 w_empty;
    logic                 w_full;
    logic [FW-1:0]        w_head;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_fall      = r_sync_d & ~r_sync2;
    assign w_timed     = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_wrap      = (r_cnt == C_LAST);
    assign w_at_h1     = (r_cnt == C_H_P1);
    // Third sample is the live synchronized value at H+1.
    assign w_vote      = maj3(r_s0, r_s1, r_sync2);
    assign w_par_exp   = (PARITY == PARITY_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_ferr_next = r_ferr | ~w_vote;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_timed) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                if (r_cnt == C_H_M1) r_s0 <= r_sync2;
                if (r_cnt == C_H)    r_s1 <= r_sync2;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_at_h1 && w_vote) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_at_h1) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_wrap) begin
                        if (r_bit_idx == C_DATA_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_at_h1) r_perr <= (w_vote != w_par_exp);
                    if (w_wrap) begin
                        r_bit_idx <= '0;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_at_h1) begin
                        r_ferr <= w_ferr_next;
                        if (r_bit_idx == C_STOP_LAST) begin
                            r_push  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= w_ferr_next ? ST_WAIT_IDLE : ST_IDLE;
                        end
                    end
                    if (w_wrap) r_bit_idx <= r_bit_idx + 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (!r_sync2) begin
                        r_cnt <= '0;
                    end else if (w_wrap) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .i_wr_en   (r_push),
        .i_wr_data ({r_shift, r_perr, r_ferr}),
        .i_rd_en   (rx_ready),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_overrun (overrun)
    );

    assign rx_valid      = ~w_empty;
    assign rx_data       = w_head[FW-1:2];
    assign rx_parity_err = w_head[1];
    assign rx_frame_err  = w_head[0];

endmodule
